// File: rtl/axis_burst_pkg.sv
// -----------------------------------------------------------------------------
// axis_burst_pkg
// Shared definitions for the AXI4-Stream burst sequencer:
//   - burst_state_e : controller state (IDLE, RUN, GAP), 2-bit encoding
//   - width defaults for the data path and the burst/gap/status counters
// -----------------------------------------------------------------------------
package axis_burst_pkg;

  localparam int unsigned AXIS_TDATA_WIDTH_DEF = 32;
  localparam int unsigned CNTR_WIDTH_DEF       = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } burst_state_e;

endpackage

// File: rtl/axis_burst_gap_timer.sv
// -----------------------------------------------------------------------------
// axis_burst_gap_timer
// Loadable down-counter that times the idle gap between bursts.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   load_i   : load value_i into the counter
//   value_i  : number of cycles to count
//   done_o   : high in the last counted cycle (counter == 1)
// After a load of N (N >= 1) done_o rises N cycles later counting from the
// cycle following the load edge, i.e. in the N-th cycle of the gap.
// -----------------------------------------------------------------------------
module axis_burst_gap_timer
  import axis_burst_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH = CNTR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [CNTR_WIDTH-1:0] value_i,
  output logic                  done_o
);

  localparam logic [CNTR_WIDTH-1:0] C_ONE = CNTR_WIDTH'(1);

  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - C_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == C_ONE);

endmodule

// File: rtl/axis_burst_sequencer.sv
// -----------------------------------------------------------------------------
// axis_burst_sequencer
// Emits programmable bursts of an incrementing counter on an AXI4-Stream
// master: cfg_length beats per burst, cfg_gap idle cycles between bursts,
// cfg_bursts bursts per run. A run is started by a pulse on start and may be
// cut short by abort (takes effect at the next burst boundary, or at once
// while in the gap).
//
// Ports:
//   aclk, areset           : clock, synchronous active-high reset
//   cfg_start_data         : first counter value of a run
//   cfg_length/gap/bursts  : beats per burst / idle cycles / bursts per run
//   start, abort           : single-cycle run request / stop request
//   busy                   : high whenever the controller is not idle
//   sts_bursts_done        : bursts completed in the current or last run
//   m_axis_tdata/tvalid/tready/tlast : stream master
//
// Build option AXIS_BURST_RELOAD_EN: when defined, every burst restarts the
// ramp at cfg_start_data; otherwise the ramp continues across the whole run.
// -----------------------------------------------------------------------------
module axis_burst_sequencer
  import axis_burst_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = AXIS_TDATA_WIDTH_DEF,
  parameter int unsigned CNTR_WIDTH       = CNTR_WIDTH_DEF
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_start_data,
  input  logic [CNTR_WIDTH-1:0]       cfg_length,
  input  logic [CNTR_WIDTH-1:0]       cfg_gap,
  input  logic [CNTR_WIDTH-1:0]       cfg_bursts,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic [CNTR_WIDTH-1:0]       sts_bursts_done,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  localparam logic [CNTR_WIDTH-1:0]       C_ONE = CNTR_WIDTH'(1);
  localparam logic [AXIS_TDATA_WIDTH-1:0] D_ONE = AXIS_TDATA_WIDTH'(1);

  burst_state_e                state_q;
  logic [AXIS_TDATA_WIDTH-1:0] data_q;
  logic [CNTR_WIDTH-1:0]       len_q, gap_q, bursts_q;
  logic [CNTR_WIDTH-1:0]       beat_q, done_q;
  logic                        tvalid_q, tlast_q, abort_pend_q;
`ifdef AXIS_BURST_RELOAD_EN
  logic [AXIS_TDATA_WIDTH-1:0] start_data_q;
`endif

  logic hs, burst_end, run_end, gap_load, gap_done, start_ok;

  always_comb begin
    hs        = (state_q == ST_RUN) && tvalid_q && m_axis_tready;
    burst_end = hs && tlast_q;
    // An abort arriving together with the closing beat ends the run as well.
    run_end   = burst_end && ((done_q + C_ONE == bursts_q) || abort_pend_q || abort);
    gap_load  = burst_end && !run_end && (gap_q != '0);
    start_ok  = start && (cfg_length != '0) && (cfg_bursts != '0);
  end

  axis_burst_gap_timer #(
    .CNTR_WIDTH (CNTR_WIDTH)
  ) u_gap_timer (
    .clk_i   (aclk),
    .rst_i   (areset),
    .load_i  (gap_load),
    .value_i (gap_q),
    .done_o  (gap_done)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      bursts_q     <= '0;
      beat_q       <= '0;
      done_q       <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      abort_pend_q <= 1'b0;
`ifdef AXIS_BURST_RELOAD_EN
      start_data_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            len_q        <= cfg_length;
            gap_q        <= cfg_gap;
            bursts_q     <= cfg_bursts;
`ifdef AXIS_BURST_RELOAD_EN
            start_data_q <= cfg_start_data;
`endif
            data_q       <= cfg_start_data;
            beat_q       <= '0;
            done_q       <= '0;
            abort_pend_q <= 1'b0;
            tvalid_q     <= 1'b1;
            tlast_q      <= (cfg_length == C_ONE);
            state_q      <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (abort) begin
            abort_pend_q <= 1'b1;
          end
          if (hs) begin
            if (tlast_q) begin
              done_q <= done_q + C_ONE;
              beat_q <= '0;
`ifdef AXIS_BURST_RELOAD_EN
              data_q <= start_data_q;
`else
              data_q <= data_q + D_ONE;
`endif
              if (run_end) begin
                abort_pend_q <= 1'b0;
                tvalid_q     <= 1'b0;
                tlast_q      <= 1'b0;
                state_q      <= ST_IDLE;
              end else if (gap_q == '0) begin
                tlast_q <= (len_q == C_ONE);
              end else begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                state_q  <= ST_GAP;
              end
            end else begin
              data_q  <= data_q + D_ONE;
              beat_q  <= beat_q + C_ONE;
              tlast_q <= (beat_q + C_ONE == len_q - C_ONE);
            end
          end
        end

        ST_GAP: begin
          if (abort) begin
            abort_pend_q <= 1'b0;
            state_q      <= ST_IDLE;
          end else if (gap_done) begin
            tvalid_q <= 1'b1;
            tlast_q  <= (len_q == C_ONE);
            state_q  <= ST_RUN;
          end
        end

        default: begin
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign sts_bursts_done = done_q;
  assign m_axis_tdata    = data_q;
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;

endmodule
